// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: valid/ready in, registered result out, iterative shifts.
// Ports: clk, rst, flush, in_valid/in_ready, op_a, op_b, alu_control, out_valid/out_ready, result, zero.
module alu_exec_unit #(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [3:0]      alu_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] result_n;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] shifted;
  logic [CW-1:0]   rem, rem_n;
  logic [CW-1:0]   step_k;
  logic [1:0]      kind, kind_n;
  logic [SW-1:0]   shamt;
  logic            accept;
  logic            is_shift;

  assign shamt     = op_b[SW-1:0];
  assign in_ready  = (state == IDLE) ||
                     (state == DONE && out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign zero      = (result == '0);
  assign is_shift  = (alu_control == 4'b1001) ||
                     (alu_control == 4'b1010) ||
                     (alu_control == 4'b1011);
  assign step_k    = (rem < STEP) ? rem : STEP;

  always_comb begin
    alu_y = '0;
    case (alu_control)
      4'b0000: alu_y = op_a & op_b;
      4'b0001: alu_y = op_a | op_b;
      4'b0010: alu_y = op_a + op_b;
      4'b0110: alu_y = op_a - op_b;
      4'b1000: alu_y = op_a ^ op_b;
      4'b0111: alu_y = {{(XLEN-1){1'b0}},
                        ($signed(op_a) < $signed(op_b))};
      4'b1100: alu_y = {{(XLEN-1){1'b0}},
                        (op_a < op_b)};
      default: alu_y = '0;
    endcase
  end

  // Only constant shifts of 1..SHIFT_STEP are built and muxed.
  // SRA keeps the MSB each step, so the original sign is preserved.
  always_comb begin
    shifted = result;
    for (int i = 1; i <= SHIFT_STEP; i++) begin
      if (step_k == CW'(i)) begin
        case (kind)
          2'b01:   shifted = result << i;
          2'b10:   shifted = result >> i;
          default: shifted = XLEN'($signed(result) >>> i);
        endcase
      end
    end
  end

  always_comb begin
    state_n  = state;
    result_n = result;
    rem_n    = rem;
    kind_n   = kind;
    if (flush) begin
      state_n = IDLE;
      rem_n   = '0;
    end else if (accept) begin
      kind_n = alu_control[1:0];
      if (is_shift) begin
        result_n = op_a;
        rem_n    = {1'b0, shamt};
        state_n  = (shamt == '0) ? DONE : SHIFT;
      end else begin
        result_n = alu_y;
        rem_n    = '0;
        state_n  = DONE;
      end
    end else begin
      case (state)
        SHIFT: begin
          result_n = shifted;
          rem_n    = rem - step_k;
          if (rem == step_k) state_n = DONE;
        end
        DONE: begin
          if (out_ready) state_n = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      rem    <= '0;
      kind   <= '0;
    end else begin
      state  <= state_n;
      result <= result_n;
      rem    <= rem_n;
      kind   <= kind_n;
    end
  end

endmodule
